// File: rtl/cpu_coin_conditioner.sv
// Coin-door conditioner: debounces the left/right coin switches and turns CPU
// counter requests into timed coin-counter coil pulses with a 3-bit backlog.
module cpu_coin_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES  = 16,
  parameter int unsigned PULSE_ON_CYCLES  = 64,
  parameter int unsigned PULSE_OFF_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RESET_AL,
  input  logic       LEFT_COIN_RAW_AL,
  input  logic       RIGHT_COIN_RAW_AL,
  input  logic       COIN_CNTR_REQ_1,
  input  logic       COIN_CNTR_REQ_2,
  output logic       LEFT_COIN_INPUT,
  output logic       RIGHT_COIN_INPUT,
  output logic       COIN_CNTR_1,
  output logic       COIN_CNTR_2,
  output logic [1:0] COIN_OVF
);

  localparam int unsigned DB_W  = 8;
  localparam int unsigned TMR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } cntr_state_e;

  // Bit 0 is the left coin / counter 1, bit 1 the right coin / counter 2.
  logic [1:0] raw_open, req_in;
  assign raw_open = {RIGHT_COIN_RAW_AL, LEFT_COIN_RAW_AL};
  assign req_in   = {COIN_CNTR_REQ_2, COIN_CNTR_REQ_1};

  logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d, sync_closed;
  logic [1:0]       filt_q, filt_d;
  logic [DB_W-1:0]  db_cnt_q [2];
  logic [DB_W-1:0]  db_cnt_d [2];

  logic [1:0]       req_q, req_d, drive_q, drive_d, ovf_q, ovf_d;
  logic [1:0]       rise, start;
  cntr_state_e      state_q [2];
  cntr_state_e      state_d [2];
  logic [2:0]       pend_q [2];
  logic [2:0]       pend_d [2];
  logic [TMR_W-1:0] tmr_q [2];
  logic [TMR_W-1:0] tmr_d [2];

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
    sync1_d     = raw_open;
    sync2_d     = sync1_q;
    sync_closed = ~sync2_q;
    filt_d      = filt_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync_closed[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[i] = sync_closed[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_d   = req_in;
    drive_d = drive_q;
    ovf_d   = ovf_q;
    rise    = req_in & ~req_q;
    start   = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      pend_d[i]  = pend_q[i];
      tmr_d[i]   = tmr_q[i];
      start[i]   = (state_q[i] == ST_IDLE) && (pend_q[i] != 3'd0);

      // A request landing on a decrement edge cancels it out and never overflows.
      if (rise[i] && !start[i]) begin
        if (pend_q[i] == 3'd7) ovf_d[i] = 1'b1;
        else                   pend_d[i] = pend_q[i] + 3'd1;
      end else if (start[i] && !rise[i]) begin
        pend_d[i] = pend_q[i] - 3'd1;
      end

      case (state_q[i])
        ST_IDLE: begin
          if (start[i]) begin
            state_d[i] = ST_ON;
            tmr_d[i]   = TMR_W'(PULSE_ON_CYCLES - 1);
            drive_d[i] = 1'b1;
          end
        end
        ST_ON: begin
          if (tmr_q[i] == '0) begin
            state_d[i] = ST_OFF;
            tmr_d[i]   = TMR_W'(PULSE_OFF_CYCLES - 1);
            drive_d[i] = 1'b0;
          end else begin
            tmr_d[i] = tmr_q[i] - 1'b1;
          end
        end
        ST_OFF: begin
          if (tmr_q[i] == '0) state_d[i] = ST_IDLE;
          else                tmr_d[i]   = tmr_q[i] - 1'b1;
        end
        default: begin
          state_d[i] = ST_IDLE;
          tmr_d[i]   = '0;
          drive_d[i] = 1'b0;
        end
      endcase
    end
  end

  // Synchronisers reset to "switch open" so reset release never looks like a coin.
  always_ff @(posedge CLK or negedge RESET_AL) begin
    if (!RESET_AL) begin
      sync1_q <= '1;
      sync2_q <= '1;
      filt_q  <= '0;
      req_q   <= '0;
      drive_q <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
        state_q[i]  <= ST_IDLE;
        pend_q[i]   <= '0;
        tmr_q[i]    <= '0;
      end
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values whatever the statement order.
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      req_q   <= req_d;
      drive_q <= drive_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        state_q[i]  <= state_d[i];
        pend_q[i]   <= pend_d[i];
        tmr_q[i]    <= tmr_d[i];
      end
    end
  end

  assign LEFT_COIN_INPUT  = filt_q[0];
  assign RIGHT_COIN_INPUT = filt_q[1];
  assign COIN_CNTR_1      = drive_q[0];
  assign COIN_CNTR_2      = drive_q[1];
  assign COIN_OVF         = ovf_q;

endmodule

// File: tb/tb_cpu_coin_conditioner.sv
// Self-checking bench for cpu_coin_conditioner: directed scenarios plus random
// traffic, every output compared each cycle against a behavioural model.
module tb_cpu_coin_conditioner;

  localparam int DB  = 4;
  localparam int ON  = 3;
  localparam int OFF = 2;

  logic       CLK = 1'b0;
  logic       RESET_AL;
  logic       left_raw, right_raw, req1, req2;
  logic       LEFT_COIN_INPUT, RIGHT_COIN_INPUT, COIN_CNTR_1, COIN_CNTR_2;
  logic [1:0] COIN_OVF;

  always #5 CLK = ~CLK;

  cpu_coin_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .PULSE_ON_CYCLES (ON),
    .PULSE_OFF_CYCLES(OFF)
  ) dut (
    .CLK              (CLK),
    .RESET_AL         (RESET_AL),
    .LEFT_COIN_RAW_AL (left_raw),
    .RIGHT_COIN_RAW_AL(right_raw),
    .COIN_CNTR_REQ_1  (req1),
    .COIN_CNTR_REQ_2  (req2),
    .LEFT_COIN_INPUT  (LEFT_COIN_INPUT),
    .RIGHT_COIN_INPUT (RIGHT_COIN_INPUT),
    .COIN_CNTR_1      (COIN_CNTR_1),
    .COIN_CNTR_2      (COIN_CNTR_2),
    .COIN_OVF         (COIN_OVF)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. Debounce: raw history per edge; the level flips once the
  // last DB synchronised samples (raw delayed two edges) all disagree with it.
  // Counters: a pulse may start on any edge at least ON+OFF+1 after the last one.
  bit hist [2][DB+2];
  bit m_filt [2];
  bit m_prev [2];
  int m_pend [2];
  bit m_started [2];
  int m_last [2];
  bit m_ovf [2];
  bit m_drive [2];
  int m_pulses [2];
  int e;

  int dut_pulses [2];
  bit dut_prev [2];
  int starts2 [$];
  int tb_cyc = 0;

  function automatic void model_init();
    e = 0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DB + 2; k++) hist[i][k] = 1'b1;
      m_filt[i] = 0; m_prev[i] = 0; m_pend[i] = 0; m_started[i] = 0;
      m_last[i] = 0; m_ovf[i] = 0; m_drive[i] = 0; m_pulses[i] = 0;
    end
  endfunction

  function automatic void model_edge(input bit raw_l, input bit raw_r, input bit r1, input bit r2);
    bit raw [2];
    bit rq [2];
    raw[0] = raw_l; raw[1] = raw_r; rq[0] = r1; rq[1] = r2;
    e++;
    for (int i = 0; i < 2; i++) begin
      bit all_disagree;
      bit rise;
      bit dec;
      for (int k = 0; k < DB + 1; k++) hist[i][k] = hist[i][k+1];
      hist[i][DB+1] = raw[i];
      // Closed level is ~raw, so "disagrees with filter" means raw == filter.
      all_disagree = 1;
      for (int k = 0; k < DB; k++) if (hist[i][k] != m_filt[i]) all_disagree = 0;
      if (all_disagree) m_filt[i] = !m_filt[i];

      rise = rq[i] && !m_prev[i];
      m_prev[i] = rq[i];
      dec = (!m_started[i] || (e - m_last[i] >= ON + OFF + 1)) && (m_pend[i] > 0);
      if (rise && !dec) begin
        if (m_pend[i] == 7) m_ovf[i] = 1;
        else                m_pend[i]++;
      end else if (dec && !rise) begin
        m_pend[i]--;
      end
      if (dec) begin
        m_started[i] = 1;
        m_last[i]    = e;
        m_pulses[i]++;
      end
      m_drive[i] = m_started[i] && (e - m_last[i] < ON);
    end
  endfunction

  task automatic tick();
    bit cur [2];
    @(posedge CLK);
    model_edge(left_raw, right_raw, req1, req2);
    #1;
    tb_cyc++;
    check("left_in",  LEFT_COIN_INPUT,  m_filt[0]);
    check("right_in", RIGHT_COIN_INPUT, m_filt[1]);
    check("cntr1",    COIN_CNTR_1,      m_drive[0]);
    check("cntr2",    COIN_CNTR_2,      m_drive[1]);
    check("ovf",      COIN_OVF,         {m_ovf[1], m_ovf[0]});
    cur[0] = COIN_CNTR_1;
    cur[1] = COIN_CNTR_2;
    for (int i = 0; i < 2; i++) begin
      if (cur[i] && !dut_prev[i]) begin
        dut_pulses[i]++;
        if (i == 1) starts2.push_back(tb_cyc);
      end
      dut_prev[i] = cur[i];
    end
  endtask

  // Asserts reset mid-cycle, checks outputs drop without a clock, releases on a falling edge.
  task automatic do_reset(input bit hold_req1);
    RESET_AL  = 1'b0;
    left_raw  = 1'b1;
    right_raw = 1'b1;
    req1      = hold_req1;
    req2      = 1'b0;
    #1;
    check("rst_left",  LEFT_COIN_INPUT,  1'b0);
    check("rst_right", RIGHT_COIN_INPUT, 1'b0);
    check("rst_cntr1", COIN_CNTR_1,      1'b0);
    check("rst_cntr2", COIN_CNTR_2,      1'b0);
    check("rst_ovf",   COIN_OVF,         2'b00);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_AL = 1'b1;
    model_init();
    for (int i = 0; i < 2; i++) begin
      dut_pulses[i] = 0;
      dut_prev[i]   = 0;
    end
    starts2.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;
    int p0;
    bit seen;

    do_reset(1'b0);

    // Held left coin: rises DB+2 edges after first sample, falls likewise on release.
    left_raw = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!LEFT_COIN_INPUT && n < 30);
    check("left_rise_lat", n, DB + 2);
    repeat (3) tick();
    left_raw = 1'b1;
    n = 0;
    do begin tick(); n++; end while (LEFT_COIN_INPUT && n < 30);
    check("left_fall_lat", n, DB + 2);

    // Right glitch of 3 samples, shorter than DB, must be ignored.
    seen = 0;
    right_raw = 1'b0;
    repeat (3) begin tick(); seen |= RIGHT_COIN_INPUT; end
    right_raw = 1'b1;
    repeat (10) begin tick(); seen |= RIGHT_COIN_INPUT; end
    check("right_glitch", seen, 1'b0);

    // Single counter-1 request: coil high on the 2nd edge, for ON clocks.
    req1 = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!COIN_CNTR_1 && n < 20);
    check("cntr1_lat", n, 2);
    req1 = 1'b0;
    w = 0;
    while (COIN_CNTR_1 && w < 20) begin w++; tick(); end
    check("cntr1_width", w, ON);
    repeat (10) tick();
    check("cntr1_pulses", dut_pulses[0], 1);
    check("cntr2_idle", dut_pulses[1], 0);

    // Four quick counter-2 requests: four pulses, ON+OFF+1 apart, no overflow.
    starts2.delete();
    p0 = dut_pulses[1];
    for (int k = 0; k < 4; k++) begin
      req2 = 1'b1; tick();
      req2 = 1'b0; tick();
    end
    repeat (40) tick();
    check("ch2_pulses", dut_pulses[1] - p0, 4);
    if (starts2.size() >= 2) check("ch2_period", starts2[1] - starts2[0], ON + OFF + 1);
    else                     check("ch2_period_seen", starts2.size(), 2);
    check("ch2_ovf", COIN_OVF, 2'b00);

    // Sixteen requests every other edge on counter 1: backlog saturates, four dropped.
    do_reset(1'b0);
    for (int k = 0; k < 16; k++) begin
      req1 = 1'b1; tick();
      req1 = 1'b0; tick();
    end
    repeat (100) tick();
    check("ch1_ovf_bit", COIN_OVF[0], 1'b1);
    check("ch1_ovf_other", COIN_OVF[1], 1'b0);
    check("ch1_pulses", dut_pulses[0], 12);

    // Reset in the second clock of a pulse with two pending: drop at once, nothing after.
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) begin
      req1 = 1'b1; tick();
      req1 = 1'b0; tick();
    end
    tick();
    check("mid_pulse_drive", COIN_CNTR_1, 1'b1);
    do_reset(1'b0);
    repeat (30) tick();
    check("post_reset_pulses", dut_pulses[0], 0);

    // Request already high at reset release counts as a new request.
    do_reset(1'b1);
    tick();
    tick();
    check("req_high_at_release", COIN_CNTR_1, 1'b1);
    req1 = 1'b0;
    repeat (10) tick();

    // Random traffic on all four channels, alternating light and heavy request rates.
    do_reset(1'b0);
    for (int c = 0; c < 4000; c++) begin
      int rate;
      rate = ((c / 400) % 2 == 1) ? 60 : 8;
      if ($urandom_range(0, 9) == 0) left_raw  = ~left_raw;
      if ($urandom_range(0, 7) == 0) right_raw = ~right_raw;
      if ($urandom_range(0, 99) < rate) req1 = ~req1;
      if ($urandom_range(0, 99) < rate) req2 = ~req2;
      if (c == 2000) do_reset(req1);
      tick();
    end
    check("rand_pulses1", dut_pulses[0], m_pulses[0]);
    check("rand_pulses2", dut_pulses[1], m_pulses[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
